// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OpMultu = 2'b00,
    OpMult  = 2'b01,
    OpDivu  = 2'b10,
    OpDiv   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFixup,
    StDone
  } state_e;

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             flush_i;
  logic             hilo_we_i;
  logic             hilo_sel_i;
  logic [WIDTH-1:0] wdata_i;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  logic             div_by_zero_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i, hilo_we_i, hilo_sel_i, wdata_i,
    input  busy_o, done_o, hi_o, lo_o, div_by_zero_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i, hilo_we_i, hilo_sel_i, wdata_i,
    output busy_o, done_o, hi_o, lo_o, div_by_zero_o
  );
endinterface

// File: rtl/muldiv_unit_cond_negate.sv
// Conditional two's-complement negation, used for magnitudes and sign fix-up.
module cond_negate #(
    parameter int unsigned W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);
  assign y = neg ? -a : a;
endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide with architectural HI/LO.
// Signed ops run on operand magnitudes; signs are restored in FIXUP.
module muldiv_unit
  import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, mag_b_q, orig_a_q;
  logic             is_div_q, neg_res_q, neg_rem_q, dbz_pend_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             busy_q, done_q, dbz_q;

  op_e              op;
  logic             op_signed, op_div, neg_a, neg_b, accept;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_sub;
  logic             rem_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  assign op        = op_e'(bus.op_i);
  assign op_signed = (op == OpMult) || (op == OpDiv);
  assign op_div    = (op == OpDivu) || (op == OpDiv);
  assign neg_a     = op_signed & bus.a_i[WIDTH-1];
  assign neg_b     = op_signed & bus.b_i[WIDTH-1];
  assign accept    = ((state_q == StIdle) || (state_q == StDone)) && bus.start_i && !bus.flush_i;

  cond_negate #(.W(WIDTH)) u_abs_a (.neg(neg_a), .a(bus.a_i), .y(abs_a));
  cond_negate #(.W(WIDTH)) u_abs_b (.neg(neg_b), .a(bus.b_i), .y(abs_b));

  // Multiply: add multiplicand when the low bit is set, shift the pair right.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, mag_b_q} : '0);
  // Divide: shift the dividend bit into the partial remainder, subtract if it fits.
  assign rem_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign rem_ge  = rem_sh >= {1'b0, mag_b_q};
  assign rem_sub = rem_sh - {1'b0, mag_b_q};

  cond_negate #(.W(2*WIDTH)) u_fix_prod (
    .neg(neg_res_q), .a({acc_hi_q, acc_lo_q}), .y(prod_fix)
  );
  cond_negate #(.W(WIDTH)) u_fix_quot (.neg(neg_res_q), .a(acc_lo_q), .y(quot_fix));
  cond_negate #(.W(WIDTH)) u_fix_rem  (.neg(neg_rem_q), .a(acc_hi_q), .y(rem_fix));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      mag_b_q    <= '0;
      orig_a_q   <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          done_q <= 1'b0;
          if (bus.hilo_we_i) begin
            if (bus.hilo_sel_i) hi_q <= bus.wdata_i;
            else                lo_q <= bus.wdata_i;
          end
          if (accept) begin
            state_q    <= StCalc;
            busy_q     <= 1'b1;
            cnt_q      <= CNT_W'(WIDTH - 1);
            acc_hi_q   <= '0;
            acc_lo_q   <= abs_a;
            mag_b_q    <= abs_b;
            orig_a_q   <= bus.a_i;
            is_div_q   <= op_div;
            neg_res_q  <= neg_a ^ neg_b;
            neg_rem_q  <= neg_a;
            dbz_pend_q <= op_div && (bus.b_i == '0);
            dbz_q      <= 1'b0;
          end else begin
            state_q <= StIdle;
          end
        end
        StCalc: begin
          if (bus.flush_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            if (is_div_q) begin
              acc_hi_q <= rem_ge ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
              acc_lo_q <= {acc_lo_q[WIDTH-2:0], rem_ge};
            end else begin
              {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
            end
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_q <= StFixup;
          end
        end
        StFixup: begin
          busy_q <= 1'b0;
          if (bus.flush_i) begin
            state_q <= StIdle;
          end else begin
            state_q <= StDone;
            done_q  <= 1'b1;
            if (dbz_pend_q) begin
              hi_q  <= orig_a_q;
              lo_q  <= '1;
              dbz_q <= 1'b1;
            end else if (is_div_q) begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.hi_o          = hi_q;
  assign bus.lo_o          = lo_q;
  assign bus.div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and random checks of muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];

  muldiv_unit_if #(.WIDTH(32)) bus ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    logic [63:0] p;
    e.dbz = 1'b0;
    case (op)
      2'b00: begin
        p = {32'd0, a} * {32'd0, b};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (b == 32'd0) begin
          e.hi = a;
          e.lo = 32'hFFFF_FFFF;
          e.dbz = 1'b1;
        end else if (op == 2'b10) begin
          e.lo = a / b;
          e.hi = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.lo = 32'h8000_0000;
          e.hi = 32'd0;
        end else begin
          e.lo = $signed(a) / $signed(b);
          e.hi = $signed(a) % $signed(b);
        end
      end
    endcase
    return e;
  endfunction

  // Launch one op (start is driven in the current cycle), wait for done, score it.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input exp_t e, output int done_cyc);
    int   lat;
    int   busy_cnt;
    exp_t got;
    sb.push_back(e);
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    check({tag, "_accept_busy"}, 64'(bus.busy_o), 64'(1));
    check({tag, "_dbz_cleared"}, 64'(bus.div_by_zero_o), 64'(0));
    lat = 1;
    busy_cnt = int'(bus.busy_o);
    while (!bus.done_o && lat < 40) begin
      tick();
      lat++;
      busy_cnt += int'(bus.busy_o);
    end
    done_cyc = cyc;
    check({tag, "_latency"}, 64'(lat), 64'(34));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(33));
    got = sb.pop_front();
    check({tag, "_hi"}, 64'(bus.hi_o), 64'(got.hi));
    check({tag, "_lo"}, 64'(bus.lo_o), 64'(got.lo));
    check({tag, "_dbz"}, 64'(bus.div_by_zero_o), 64'(got.dbz));
  endtask

  initial begin
    int          d0, d1, dcount;
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    reset          = 1'b1;
    bus.start_i    = 1'b0;
    bus.op_i       = 2'b00;
    bus.a_i        = '0;
    bus.b_i        = '0;
    bus.flush_i    = 1'b0;
    bus.hilo_we_i  = 1'b0;
    bus.hilo_sel_i = 1'b0;
    bus.wdata_i    = '0;
    tick();
    tick();
    reset = 1'b0;
    check("reset_outputs", {29'd0, bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.hi_o | bus.lo_o},
          64'd0);

    // Test 1
    run_op("t1_multu", 2'b00, 32'hFFFF_FFFF, 32'd2, '{32'h1, 32'hFFFF_FFFE, 1'b0}, d0);
    tick();
    // Test 2
    run_op("t2_mult", 2'b01, -32'sd3, 32'd5, '{32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0}, d0);
    tick();
    run_op("t2_div", 2'b11, -32'sd7, 32'd2, '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0}, d0);
    tick();
    // Test 3
    run_op("t3_divu0", 2'b10, 32'd100, 32'd0, '{32'h64, 32'hFFFF_FFFF, 1'b1}, d0);
    tick();
    check("t3_dbz_sticky", 64'(bus.div_by_zero_o), 64'(1));
    run_op("t3_multu", 2'b00, 32'd6, 32'd7, '{32'd0, 32'd42, 1'b0}, d0);
    tick();
    // Test 4
    run_op("t4_minneg1", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, '{32'd0, 32'h8000_0000, 1'b0}, d0);
    tick();

    for (int i = 0; i < 8; i++) begin
      rop = 2'(i % 4);
      ra  = $urandom;
      rb  = (i % 3 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 7) rb = -32'sd13;
      run_op($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb), d0);
      tick();
    end

    // Test 5: MTLO, then a flushed multiply with ignored start/MT writes while busy
    bus.hilo_we_i  = 1'b1;
    bus.hilo_sel_i = 1'b0;
    bus.wdata_i    = 32'h1234;
    tick();
    bus.hilo_we_i = 1'b0;
    check("t5_mtlo", 64'(bus.lo_o), 64'h1234);
    bus.op_i    = 2'b00;
    bus.a_i     = 32'd3;
    bus.b_i     = 32'd4;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    tick();
    tick();
    bus.start_i   = 1'b1;
    bus.op_i      = 2'b10;
    bus.hilo_we_i = 1'b1;
    bus.wdata_i   = 32'hDEAD;
    tick();
    bus.start_i   = 1'b0;
    bus.hilo_we_i = 1'b0;
    check("t5_mt_ignored_busy", 64'(bus.lo_o), 64'h1234);
    while (cyc < d0) tick();
    for (int i = 0; i < 6; i++) tick();
    check("t5_busy_before_flush", 64'(bus.busy_o), 64'(1));
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("t5_busy_after_flush", 64'(bus.busy_o), 64'(0));
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      dcount += int'(bus.done_o);
    end
    check("t5_no_done", 64'(dcount), 64'(0));
    check("t5_lo_kept", 64'(bus.lo_o), 64'h1234);

    // Test 6: second start issued during the DONE cycle of the first
    run_op("t6_a", 2'b01, 32'd1000, -32'sd9, model(2'b01, 32'd1000, -32'sd9), d0);
    run_op("t6_b", 2'b10, 32'd1000, 32'd7, model(2'b10, 32'd1000, 32'd7), d1);
    check("t6_done_spacing", 64'(d1 - d0), 64'(34));
    tick();

    bus.op_i    = 2'b00;
    bus.a_i     = 32'd5;
    bus.b_i     = 32'd5;
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t6_reset_outputs",
          {29'd0, bus.busy_o, bus.done_o, bus.div_by_zero_o, bus.hi_o | bus.lo_o}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      dcount += int'(bus.done_o);
    end
    check("t6_no_done_after_reset", 64'(dcount), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
